nnrv_regfile: RTL and testbench

Integer register file for the nnrv RISC-V core: the sink end of the writeback interface. It accepts one register write per cycle from the writeback stage and serves two synchronous read ports to decode. Reads have one-cycle latency and a valid flag. The read outputs hold while the pipeline is stalled. Register x0 is hardwired to zero.

---
 rtl/nnrv_regfile.sv | 89 ++++++++
 tb/tb_nnrv_regfile.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nnrv_regfile.sv
// nnrv integer register file: x1..x31 storage, one write port, two registered read ports.
// Optional same-edge write-to-read bypass: define NNRV_REGFILE_BYPASS_EN.
module nnrv_regfile #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_reg_w_en,
   input  logic [4:0]      i_reg_w,
   input  logic [XLEN-1:0] i_reg_w_reg,
   input  logic            i_rd_en,
   input  logic [4:0]      i_rs1,
   input  logic [4:0]      i_rs2,
   input  logic            i_stall,
   output logic [XLEN-1:0] o_rs1_reg,
   output logic [XLEN-1:0] o_rs2_reg,
   output logic            o_rd_valid
);

   logic [XLEN-1:0] regs [1:31];
   logic            wr_fire;
   logic [XLEN-1:0] rs1_val_p0;
   logic [XLEN-1:0] rs2_val_p0;
   logic [XLEN-1:0] rs1_p1;
   logic [XLEN-1:0] rs2_p1;
   logic            vld_p1;

   assign wr_fire = i_reg_w_en && (i_reg_w != 5'd0);

   // x0 never reaches storage; the write side ignores it entirely.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_fire) begin
         regs[i_reg_w] <= i_reg_w_reg;
      end
   end

   function automatic logic [XLEN-1:0] read_val(input logic [4:0] idx,
                                                input logic [XLEN-1:0] stored);
      logic [XLEN-1:0] v;
      v = stored;
`ifdef NNRV_REGFILE_BYPASS_EN
      if (wr_fire && (idx == i_reg_w)) begin
         v = i_reg_w_reg;
      end
`endif
      if (idx == 5'd0) begin
         v = '0;
      end
      return v;
   endfunction

   // Stage p0: combinational lookup of both read indices
   always_comb begin
      rs1_val_p0 = '0;
      rs2_val_p0 = '0;
      if (i_rs1 != 5'd0) begin
         rs1_val_p0 = read_val(i_rs1, regs[i_rs1]);
      end
      if (i_rs2 != 5'd0) begin
         rs2_val_p0 = read_val(i_rs2, regs[i_rs2]);
      end
   end

   // Stage p1: registered read outputs, frozen while stalled
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rs1_p1 <= '0;
         rs2_p1 <= '0;
         vld_p1 <= 1'b0;
      end else if (!i_stall) begin
         if (i_rd_en) begin
            rs1_p1 <= rs1_val_p0;
            rs2_p1 <= rs2_val_p0;
            vld_p1 <= 1'b1;
         end else begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign o_rs1_reg  = rs1_p1;
   assign o_rs2_reg  = rs2_p1;
   assign o_rd_valid = vld_p1;

endmodule

// File: tb/tb_nnrv_regfile.sv
// Directed self-checking bench for nnrv_regfile; expectations follow NNRV_REGFILE_BYPASS_EN.
module tb_nnrv_regfile;

   localparam int XLEN = 32;

   logic            i_clk;
   logic            i_rst;
   logic            i_reg_w_en;
   logic [4:0]      i_reg_w;
   logic [XLEN-1:0] i_reg_w_reg;
   logic            i_rd_en;
   logic [4:0]      i_rs1;
   logic [4:0]      i_rs2;
   logic            i_stall;
   logic [XLEN-1:0] o_rs1_reg;
   logic [XLEN-1:0] o_rs2_reg;
   logic            o_rd_valid;

   int n_checks = 0;
   int n_fail   = 0;

   nnrv_regfile #(.XLEN(XLEN)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_reg_w_en  (i_reg_w_en),
      .i_reg_w     (i_reg_w),
      .i_reg_w_reg (i_reg_w_reg),
      .i_rd_en     (i_rd_en),
      .i_rs1       (i_rs1),
      .i_rs2       (i_rs2),
      .i_stall     (i_stall),
      .o_rs1_reg   (o_rs1_reg),
      .o_rs2_reg   (o_rs2_reg),
      .o_rd_valid  (o_rd_valid)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic w_en, input logic [4:0] w, input logic [XLEN-1:0] wd,
                        input logic rd_en, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic stall);
      i_reg_w_en  = w_en;
      i_reg_w     = w;
      i_reg_w_reg = wd;
      i_rd_en     = rd_en;
      i_rs1       = rs1;
      i_rs2       = rs2;
      i_stall     = stall;
   endtask

   task automatic test_reset();
      drive(1, 5, 32'h0000_0055, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 1, 5, 5, 0);
      tick();
      n_checks++;
      if (o_rd_valid !== 1'b1 || o_rs1_reg !== 32'h55) begin
         n_fail++;
         $display("FAIL reset_pre: valid=%0b rs1=%h required valid=1 rs1=00000055", o_rd_valid, o_rs1_reg);
      end
      #2;
      i_rst = 1'b1;
      #1;
      n_checks++;
      if (o_rs1_reg !== '0 || o_rs2_reg !== '0 || o_rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: rs1=%h rs2=%h valid=%0b required 0/0/0", o_rs1_reg, o_rs2_reg, o_rd_valid);
      end
      drive(1, 5, 32'hCAFE_0005, 1, 5, 5, 0);
      tick();
      n_checks++;
      if (o_rd_valid !== 1'b0 || o_rs1_reg !== '0) begin
         n_fail++;
         $display("FAIL reset_edge: valid=%0b rs1=%h required valid=0 rs1=0", o_rd_valid, o_rs1_reg);
      end
      i_rst = 1'b0;
      drive(0, 0, 0, 1, 5, 31, 0);
      tick();
      n_checks++;
      if (o_rs1_reg !== '0 || o_rs2_reg !== '0 || o_rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_after: rs1=%h rs2=%h valid=%0b required 0/0/1", o_rs1_reg, o_rs2_reg, o_rd_valid);
      end
   endtask

   task automatic test_write_read();
      drive(1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 1, 3, 3, 0);
      tick();
      n_checks++;
      if (o_rs1_reg !== 32'hDEAD_BEEF || o_rs2_reg !== 32'hDEAD_BEEF || o_rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL write_read: rs1=%h rs2=%h valid=%0b required deadbeef/deadbeef/1", o_rs1_reg, o_rs2_reg, o_rd_valid);
      end
   endtask

   task automatic test_x0();
      drive(1, 0, 32'h1234_5678, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 1, 0, 3, 0);
      tick();
      n_checks++;
      if (o_rs1_reg !== '0 || o_rs2_reg !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL x0_read: rs1=%h rs2=%h required 00000000/deadbeef", o_rs1_reg, o_rs2_reg);
      end
      drive(1, 0, 32'h1234_5678, 1, 0, 0, 0);
      tick();
      n_checks++;
      if (o_rs1_reg !== '0 || o_rs2_reg !== '0 || o_rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL x0_same_edge: rs1=%h rs2=%h valid=%0b required 0/0/1", o_rs1_reg, o_rs2_reg, o_rd_valid);
      end
   endtask

   task automatic test_bypass();
      logic [XLEN-1:0] exp_rs1;
`ifdef NNRV_REGFILE_BYPASS_EN
      exp_rs1 = 32'h22;
`else
      exp_rs1 = 32'h11;
`endif
      drive(1, 7, 32'h11, 0, 0, 0, 0);
      tick();
      drive(1, 8, 32'h88, 0, 0, 0, 0);
      tick();
      drive(1, 7, 32'h22, 1, 7, 8, 0);
      tick();
      n_checks++;
      if (o_rs1_reg !== exp_rs1 || o_rs2_reg !== 32'h88) begin
         n_fail++;
         $display("FAIL bypass_same_edge: rs1=%h rs2=%h required %h/00000088", o_rs1_reg, o_rs2_reg, exp_rs1);
      end
      drive(0, 0, 0, 1, 8, 7, 0);
      tick();
      n_checks++;
      if (o_rs1_reg !== 32'h88 || o_rs2_reg !== 32'h22) begin
         n_fail++;
         $display("FAIL bypass_after: rs1=%h rs2=%h required 00000088/00000022", o_rs1_reg, o_rs2_reg);
      end
   endtask

   task automatic test_stall();
      drive(1, 1, 32'hA, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 1, 1, 0, 0);
      tick();
      n_checks++;
      if (o_rs1_reg !== 32'hA || o_rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_pre: rs1=%h valid=%0b required 0000000a/1", o_rs1_reg, o_rd_valid);
      end
      drive(1, 1, 32'hB, 1, 2, 1, 1);
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (o_rs1_reg !== 32'hA || o_rs2_reg !== '0 || o_rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: rs1=%h rs2=%h valid=%0b required 0000000a/0/1", c, o_rs1_reg, o_rs2_reg, o_rd_valid);
         end
      end
      drive(0, 0, 0, 1, 1, 2, 0);
      tick();
      n_checks++;
      if (o_rs1_reg !== 32'hB || o_rs2_reg !== '0 || o_rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_release: rs1=%h rs2=%h valid=%0b required 0000000b/0/1", o_rs1_reg, o_rs2_reg, o_rd_valid);
      end
   endtask

   task automatic test_valid_drop();
      drive(0, 0, 0, 1, 3, 1, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      n_checks++;
      if (o_rd_valid !== 1'b0 || o_rs1_reg !== 32'hDEAD_BEEF || o_rs2_reg !== 32'hB) begin
         n_fail++;
         $display("FAIL valid_drop: valid=%0b rs1=%h rs2=%h required 0/deadbeef/0000000b", o_rd_valid, o_rs1_reg, o_rs2_reg);
      end
      drive(0, 0, 0, 1, 7, 7, 1);
      tick();
      n_checks++;
      if (o_rd_valid !== 1'b0 || o_rs1_reg !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL stall_invalid_hold: valid=%0b rs1=%h required 0/deadbeef", o_rd_valid, o_rs1_reg);
      end
   endtask

   task automatic test_back_to_back();
      drive(1, 10, 32'h1010_1010, 0, 0, 0, 0);
      tick();
      drive(1, 11, 32'h1111_1111, 1, 10, 31, 0);
      tick();
      n_checks++;
      if (o_rs1_reg !== 32'h1010_1010 || o_rs2_reg !== '0 || o_rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first: rs1=%h rs2=%h valid=%0b required 10101010/0/1", o_rs1_reg, o_rs2_reg, o_rd_valid);
      end
      drive(0, 0, 0, 1, 11, 10, 0);
      tick();
      n_checks++;
      if (o_rs1_reg !== 32'h1111_1111 || o_rs2_reg !== 32'h1010_1010 || o_rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_second: rs1=%h rs2=%h valid=%0b required 11111111/10101010/1", o_rs1_reg, o_rs2_reg, o_rd_valid);
      end
   endtask

   initial begin
      i_rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      test_reset();
      test_write_read();
      test_x0();
      test_bypass();
      test_stall();
      test_valid_drop();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
